mainm_cache: RTL and testbench

MAINM_CACHE -- requirements
Module: mainm_cache

---
 rtl/mainm_cache_pkg.sv | 21 ++
 rtl/mainm_cache_tag_store.sv | 48 ++++
 rtl/mainm_cache.sv | 132 +++++++++++++
 tb/tb_mainm_cache.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mainm_cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache: FSM states and default geometry.
package mainm_cache_pkg;

    localparam int unsigned DEF_LINES = 64;
    localparam int unsigned DEF_IDX_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        FILL,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    function automatic int unsigned tag_width(input int unsigned idx_w);
        return 32 - idx_w - 2;
    endfunction

endpackage

// File: rtl/mainm_cache_tag_store.sv
// Valid/tag/data storage for mainm_cache: combinational read port, synchronous write port.
module cache_tag_store
    import mainm_cache_pkg::*;
#(
    parameter int unsigned LINES = DEF_LINES,
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned TAG_W = tag_width(DEF_IDX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    // A clear wins over a same-cycle line write, so a fill racing a flush stays invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/mainm_cache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate cache in front of memory_controller.
// Optional CACHE_FLUSH_EN adds a flush input that invalidates every line in one cycle.
module mainm_cache
    import mainm_cache_pkg::*;
#(
    parameter int unsigned LINES = DEF_LINES,
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
`ifdef CACHE_FLUSH_EN
    input  logic        flush,
`endif
    output logic [31:0] spo,
    output logic        ready,
    output logic [31:0] a_mem,
    output logic [31:0] d_mem,
    output logic        we_mem,
    output logic        rd_mem,
    input  logic [31:0] spo_mem,
    input  logic        ready_mem
);

    localparam int unsigned TAG_W = tag_width(IDX_W);

    state_t           state;
    logic             flush_i;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic             unused_lsb;

`ifdef CACHE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign unused_lsb = ^a[1:0];

    // In IDLE the lookup follows the live CPU address; afterwards the latched request address.
    assign lk_idx = (state == IDLE) ? a[IDX_W+1:2]     : a_mem[IDX_W+1:2];
    assign lk_tag = (state == IDLE) ? a[31:IDX_W+2]    : a_mem[31:IDX_W+2];
    assign hit    = rd_valid && (rd_tag == lk_tag) && !flush_i;

    // FILL writes the returned word (held on spo); DONE refreshes a hit line with the write data.
    assign wr_en   = (state == FILL) || ((state == DONE) && hit);
    assign wr_data = (state == FILL) ? spo : d_mem;

    cache_tag_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush_i),
        .rd_idx   (lk_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (a_mem[IDX_W+1:2]),
        .wr_tag   (a_mem[31:IDX_W+2]),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ready  <= 1'b0;
            rd_mem <= 1'b0;
            we_mem <= 1'b0;
            spo    <= '0;
            a_mem  <= '0;
            d_mem  <= '0;
        end else begin
            ready  <= 1'b0;
            rd_mem <= 1'b0;
            we_mem <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ready) begin
                        if (we) begin
                            a_mem  <= {a[31:2], 2'b00};
                            d_mem  <= d;
                            we_mem <= 1'b1;
                            state  <= WR_REQ;
                        end else if (rd) begin
                            if (hit) begin
                                ready <= 1'b1;
                                spo   <= rd_data;
                            end else begin
                                a_mem  <= {a[31:2], 2'b00};
                                rd_mem <= 1'b1;
                                state  <= RD_REQ;
                            end
                        end
                    end
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: begin
                    if (ready_mem) begin
                        spo   <= spo_mem;
                        ready <= 1'b1;
                        state <= FILL;
                    end
                end
                FILL:    state <= IDLE;
                WR_REQ:  state <= WR_WAIT;
                WR_WAIT: begin
                    if (ready_mem) begin
                        ready <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mainm_cache.sv
// Self-checking bench for mainm_cache: directed scenarios plus randomized traffic against a line/memory model.
// Exercises the flush scenario when CACHE_FLUSH_EN is defined.
module tb_mainm_cache;

    localparam int unsigned LINES = 64;
    localparam int unsigned IDX_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, d, spo, a_mem, d_mem, spo_mem;
    logic        we, rd, ready, we_mem, rd_mem, ready_mem;
`ifdef CACHE_FLUSH_EN
    logic        flush;
`endif

    mainm_cache #(.LINES(LINES), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .d         (d),
        .we        (we),
        .rd        (rd),
`ifdef CACHE_FLUSH_EN
        .flush     (flush),
`endif
        .spo       (spo),
        .ready     (ready),
        .a_mem     (a_mem),
        .d_mem     (d_mem),
        .we_mem    (we_mem),
        .rd_mem    (rd_mem),
        .spo_mem   (spo_mem),
        .ready_mem (ready_mem)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0, fails = 0;
    int unsigned n_rd = 0, n_we = 0, n_ready = 0;
    logic [31:0] last_rd_addr, last_we_addr, last_we_data, last_spo;
    logic [31:0] exp_spo = '0, spo_model = '0, prev_spo = '0;
    logic        prev_ready = 1'b0;

    // Model: what each line holds, and what main memory holds per word address.
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] mem [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic int unsigned idx_of(input logic [31:0] addr);
        return (addr >> 2) % LINES;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] addr);
        return addr >> (IDX_W + 2);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        logic [31:0] w = addr & ~32'd3;
        if (!mem.exists(w)) mem[w] = w ^ 32'h5A5A_0000;
        return mem[w];
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    // Per-cycle compare of the CPU-side response and the memory strobes.
    always @(negedge clk) begin
        if (!rst) begin
            prev_ready = 1'b0;
            prev_spo   = spo;
        end else begin
            check("mem_strobe_excl", {31'b0, rd_mem & we_mem}, 32'd0);
            if (ready) begin
                check("ready_twice", {31'b0, prev_ready}, 32'd0);
                check("spo_on_ready", spo, exp_spo);
                n_ready++;
                last_spo = spo;
            end else begin
                check("spo_hold", spo, prev_spo);
            end
            if (rd_mem) begin
                n_rd++;
                last_rd_addr = a_mem;
            end
            if (we_mem) begin
                n_we++;
                last_we_addr = a_mem;
                last_we_data = d_mem;
            end
            prev_ready = ready;
            prev_spo   = spo;
        end
    end

    // lit: -1 no literal pin, 0 DUT must miss, 1 DUT must hit.
    task automatic cpu_read(input logic [31:0] addr, input int unsigned dly, input int lit);
        int unsigned idx = idx_of(addr);
        bit          exp_hit = m_valid[idx] && (m_tag[idx] == tag_of(addr));
        logic [31:0] exp_data = exp_hit ? m_data[idx] : mem_rd(addr);
        int unsigned rd0 = n_rd, r0 = n_ready, w0 = n_we;
        exp_spo = exp_data;
        rd = 1'b1;
        a  = addr;
        wait_cyc();
        rd = 1'b0;
        check("rd_issue", n_rd - rd0, exp_hit ? 32'd0 : 32'd1);
        if (lit >= 0) check("lit_rd_issue", n_rd - rd0, (lit == 1) ? 32'd0 : 32'd1);
        if (exp_hit) begin
            check("hit_latency", n_ready - r0, 32'd1);
        end else begin
            check("rd_addr", last_rd_addr, addr & ~32'd3);
            repeat (dly) wait_cyc();
            check("rd_early_ready", n_ready - r0, 32'd0);
            spo_mem   = exp_data;
            ready_mem = 1'b1;
            wait_cyc();
            ready_mem = 1'b0;
            spo_mem   = $urandom;
            check("fill_latency", n_ready - r0, 32'd1);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag_of(addr);
            m_data[idx]  = exp_data;
        end
        check("rd_no_we", n_we - w0, 32'd0);
        spo_model = exp_data;
        wait_cyc();
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input int unsigned dly);
        int unsigned idx = idx_of(addr);
        int unsigned w0 = n_we, r0 = n_ready, rd0 = n_rd;
        exp_spo = spo_model;
        we = 1'b1;
        rd = ($urandom_range(0, 1) == 1);
        a  = addr;
        d  = data;
        wait_cyc();
        we = 1'b0;
        rd = 1'b0;
        check("wr_issue", n_we - w0, 32'd1);
        check("wr_addr", last_we_addr, addr & ~32'd3);
        check("wr_data", last_we_data, data);
        repeat (dly) wait_cyc();
        check("wr_early_ready", n_ready - r0, 32'd0);
        ready_mem = 1'b1;
        wait_cyc();
        ready_mem = 1'b0;
        check("wr_ready", n_ready - r0, 32'd1);
        check("wr_no_rd", n_rd - rd0, 32'd0);
        mem[addr & ~32'd3] = data;
        if (m_valid[idx] && m_tag[idx] == tag_of(addr)) m_data[idx] = data;
        wait_cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0, rd0;
        logic [31:0] addr;
        rst = 1'b0; a = '0; d = '0; we = 1'b0; rd = 1'b0;
        spo_mem = '0; ready_mem = 1'b0;
`ifdef CACHE_FLUSH_EN
        flush = 1'b0;
`endif
        clear_model();
        repeat (3) wait_cyc();
        check("rst_ready",  {31'b0, ready},  32'd0);
        check("rst_rd_mem", {31'b0, rd_mem}, 32'd0);
        check("rst_we_mem", {31'b0, we_mem}, 32'd0);
        check("rst_spo",    spo,   32'd0);
        check("rst_a_mem",  a_mem, 32'd0);
        check("rst_d_mem",  d_mem, 32'd0);
        rst = 1'b1;
        wait_cyc();

        // Cold miss, memory answers after 5 cycles.
        mem[32'h2000_0010] = 32'hDEAD_BEEF;
        cpu_read(32'h2000_0010, 5, 0);
        check("lit_cold_data", last_spo, 32'hDEAD_BEEF);
        check("lit_cold_addr", last_rd_addr, 32'h2000_0010);
        cpu_read(32'h2000_0010, 1, 1);
        check("lit_hit_data", last_spo, 32'hDEAD_BEEF);

        // A read strobe during the hit's ready cycle must be dropped.
        r0 = n_ready; rd0 = n_rd;
        exp_spo = 32'hDEAD_BEEF;
        rd = 1'b1; a = 32'h2000_0010;
        wait_cyc();
        a = 32'h2000_0710;
        wait_cyc();
        rd = 1'b0;
        repeat (2) wait_cyc();
        check("hit_cycle_ignore_rd", n_rd - rd0, 32'd0);
        check("hit_cycle_ignore_ready", n_ready - r0, 32'd1);

        // Write-through on a hit, then read back from the line.
        cpu_write(32'h2000_0010, 32'h1234_5678, 3);
        check("lit_wr_data", last_we_data, 32'h1234_5678);
        cpu_read(32'h2000_0010, 1, 1);
        check("lit_wr_hit_data", last_spo, 32'h1234_5678);

        // Conflict replacement at the same index.
        cpu_read(32'h2000_0110, 2, 0);
        cpu_read(32'h2000_0010, 2, 0);
        check("lit_refetch_data", last_spo, 32'h1234_5678);

        // No write-allocate.
        cpu_write(32'h2000_0200, 32'hCAFE_F00D, 2);
        cpu_read(32'h2000_0200, 2, 0);
        check("lit_noalloc_data", last_spo, 32'hCAFE_F00D);

        // Stray ready_mem in IDLE.
        r0 = n_ready;
        ready_mem = 1'b1;
        wait_cyc();
        ready_mem = 1'b0;
        wait_cyc();
        check("stray_ready_mem", n_ready - r0, 32'd0);

        // Reset in RD_WAIT abandons the fill.
        r0 = n_ready; rd0 = n_rd;
        rd = 1'b1; a = 32'h3000_0020;
        wait_cyc();
        rd = 1'b0;
        check("rst_test_issue", n_rd - rd0, 32'd1);
        repeat (2) wait_cyc();
        rst = 1'b0;
        wait_cyc();
        rst = 1'b1;
        clear_model();
        spo_model = '0;
        exp_spo = '0;
        wait_cyc();
        spo_mem = 32'hBAD0_BAD0; ready_mem = 1'b1;
        wait_cyc();
        ready_mem = 1'b0;
        repeat (3) wait_cyc();
        check("rst_abandon_ready", n_ready - r0, 32'd0);
        cpu_read(32'h3000_0020, 2, 0);
        cpu_read(32'h2000_0010, 2, 0);

`ifdef CACHE_FLUSH_EN
        cpu_read(32'h2000_0010, 1, 1);
        flush = 1'b1;
        wait_cyc();
        flush = 1'b0;
        clear_model();
        cpu_read(32'h2000_0010, 2, 0);
        cpu_read(32'h2000_0010, 1, 1);
`endif

        // Randomized traffic over a small address pool to force hits and conflicts.
        for (int i = 0; i < 300; i++) begin
            addr = 32'h2000_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)
                   | $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 6)
                cpu_read(addr, $urandom_range(1, 6), -1);
            else
                cpu_write(addr, $urandom, $urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0) begin
                r0 = n_ready;
                ready_mem = 1'b1;
                wait_cyc();
                ready_mem = 1'b0;
                wait_cyc();
                check("rand_stray_ready_mem", n_ready - r0, 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
